avalon_mem_arbiter: RTL
=======================

AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width (byte_enable is DW/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum slave wait cycles per transfer (0 disables the watchdog).
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, readdata returned on a timed-out read.
REQ-005 SHALL have clk  input  1  clock, all logic on the rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have m0_read, m1_read, m2_read  input  1 each  master read request (m0=debug host, m1=ibus, m2=dbus).
REQ-008 SHALL have m0_write, m1_write, m2_write  input  1 each  master write request.
REQ-009 SHALL have m0_address, m1_address, m2_address  input  AW each  byte address.
REQ-010 SHALL have m0_byte_enable, m1_byte_enable, m2_byte_enable  input  DW/8 each  byte lanes.
REQ-011 SHALL have m0_writedata, m1_writedata, m2_writedata  input  DW each  write data.
REQ-012 SHALL have m0_readdata, m1_readdata, m2_readdata  output  DW each  read data.
REQ-013 SHALL have m0_waitrequest, m1_waitrequest, m2_waitrequest  output  1 each  stall; low means the transfer completes this cycle.
REQ-014 SHALL have s_read, s_write  output  1  shared-memory request.
REQ-015 SHALL have s_address  output  AW;  s_byte_enable  output  DW/8;  s_writedata  output  DW.
REQ-016 SHALL have s_readdata  input  DW;  s_waitrequest  input  1  memory response.
REQ-017 SHALL have timeout_err  output  1  sticky watchdog flag;  timeout_addr  output  AW  address of the first timed-out transfer.
REQ-018 SHALL have err_clr  input  1  clears timeout_err.

Function
REQ-019 SHALL implement FSM states IDLE and BUSY, plus registered grant[1:0] (0/1/2), rr_ptr (1 or 2), and wait counter cnt.
REQ-020 In IDLE, SHALL drive s_read=s_write=0 and all mN_waitrequest=1.
REQ-021 In IDLE, when any mN_read|mN_write is set, SHALL register grant and move to BUSY; m0 has fixed highest priority; between m1 and m2 the one equal to rr_ptr wins, otherwise the sole requester wins.
REQ-022 In BUSY, SHALL combinationally forward the granted master's read/write/address/byte_enable/writedata to s_*, and forward s_waitrequest to the granted master only; non-granted masters see waitrequest=1.
REQ-023 SHALL drive mN_readdata = s_readdata for the granted master and 0 for the others.
REQ-024 Completion occurs in the BUSY cycle where s_waitrequest=0 with a request present; the FSM then returns to IDLE on the next edge, which gives a minimum latency of 2 cycles from request to completion.
REQ-025 On completion of an m1 grant, SHALL set rr_ptr=2; on an m2 grant, rr_ptr=1; an m0 grant leaves rr_ptr unchanged.
REQ-026 SHALL hold the grant until completion; new requests never preempt an active transfer, including m0.
REQ-027 If the granted master drops both read and write while BUSY, SHALL deassert s_read/s_write and return to IDLE next cycle without updating rr_ptr.
REQ-028 cnt SHALL clear on entry to BUSY and increment each BUSY cycle with s_waitrequest=1, saturating at TIMEOUT.
REQ-029 If TIMEOUT!=0 and cnt==TIMEOUT while s_waitrequest=1, SHALL force completion: granted waitrequest=0, readdata=ERR_DATA, s_read=s_write=0; return to IDLE next cycle and update rr_ptr.
REQ-030 On a forced completion with timeout_err=0, SHALL set timeout_err=1 and capture timeout_addr; later timeouts do not overwrite timeout_addr.
REQ-031 err_clr=1 SHALL clear timeout_err next cycle; a simultaneous new timeout wins (flag stays 1, address recaptured).

Reset
REQ-032 While rst_n=0, SHALL asynchronously force state=IDLE, grant=0, rr_ptr=1, cnt=0, timeout_err=0, timeout_addr=0; outputs: s_read=s_write=0, all mN_waitrequest=1, mN_readdata=0.
REQ-033 Reset asserted mid-BUSY SHALL abort the transfer immediately; no completion is signalled.

Verification
REQ-034 m1 read @0x100 alone, memory waitrequest=0 → grant in cycle 1, s_read=1 s_address=0x100 in cycle 1, m1_waitrequest=0 in cycle 1, m1_readdata=s_readdata.
REQ-035 m1 and m2 request every cycle → grants alternate m1,m2,m1,m2; the other master's waitrequest stays 1 throughout.
REQ-036 m0, m1, m2 request simultaneously in IDLE → m0 served first, then m1 (rr_ptr=1), then m2.
REQ-037 TIMEOUT=4, memory holds waitrequest=1, m2 read @0x2000 → completes on BUSY cycle 5 with readdata 0xDEADBEEF; timeout_err=1 and timeout_addr=0x2000; err_clr clears the flag.
REQ-038 rst_n pulsed low during a BUSY m1 write → s_write drops within the same cycle; after release, state IDLE and rr_ptr=1.
REQ-039 m2 drops its write mid-BUSY with memory waitrequest=1 → s_write=0 that cycle, IDLE next cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: three-master to one-slave Avalon-MM arbiter with watchdog
module avalon_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_read,
  input  logic            m1_read,
  input  logic            m2_read,
  input  logic            m0_write,
  input  logic            m1_write,
  input  logic            m2_write,
  input  logic [AW-1:0]   m0_address,
  input  logic [AW-1:0]   m1_address,
  input  logic [AW-1:0]   m2_address,
  input  logic [DW/8-1:0] m0_byte_enable,
  input  logic [DW/8-1:0] m1_byte_enable,
  input  logic [DW/8-1:0] m2_byte_enable,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW-1:0]   m2_writedata,
  output logic [DW-1:0]   m0_readdata,
  output logic [DW-1:0]   m1_readdata,
  output logic [DW-1:0]   m2_readdata,
  output logic            m0_waitrequest,
  output logic            m1_waitrequest,
  output logic            m2_waitrequest,
  output logic            s_read,
  output logic            s_write,
  output logic [AW-1:0]   s_address,
  output logic [DW/8-1:0] s_byte_enable,
  output logic [DW-1:0]   s_writedata,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_waitrequest,
  output logic            timeout_err,
  output logic [AW-1:0]   timeout_addr,
  input  logic            err_clr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [1:0] grant, rr_ptr, pick;
  logic [CW-1:0] cnt;
  logic r0, r1, r2, busy, g_read, g_write, active, forced, wait_g;
  logic [AW-1:0] g_addr;
  logic [DW/8-1:0] g_be;
  logic [DW-1:0] g_wdata, rdata;
  // Request decode, arbitration choice and granted-master mux
  always_comb begin
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    r2 = m2_read | m2_write;
    pick = r0 ? 2'd0 : (r1 && (!r2 || rr_ptr == 2'd1)) ? 2'd1 : 2'd2;
    busy = state == BUSY;
    g_read = grant == 2'd0 ? m0_read : grant == 2'd1 ? m1_read : m2_read;
    g_write = grant == 2'd0 ? m0_write : grant == 2'd1 ? m1_write : m2_write;
    g_addr = grant == 2'd0 ? m0_address : grant == 2'd1 ? m1_address : m2_address;
    g_be = grant == 2'd0 ? m0_byte_enable : grant == 2'd1 ? m1_byte_enable : m2_byte_enable;
    g_wdata = grant == 2'd0 ? m0_writedata : grant == 2'd1 ? m1_writedata : m2_writedata;
    active = busy && (g_read || g_write);
    forced = active && s_waitrequest && TIMEOUT != 0 && cnt == TMAX;
    wait_g = s_waitrequest & ~forced;
    rdata = forced ? ERR_DATA : s_readdata;
  end
  assign s_read = busy & g_read & ~forced;
  assign s_write = busy & g_write & ~forced;
  assign s_address = g_addr;
  assign s_byte_enable = g_be;
  assign s_writedata = g_wdata;
  assign m0_waitrequest = (busy && grant == 2'd0) ? wait_g : 1'b1;
  assign m1_waitrequest = (busy && grant == 2'd1) ? wait_g : 1'b1;
  assign m2_waitrequest = (busy && grant == 2'd2) ? wait_g : 1'b1;
  assign m0_readdata = (busy && grant == 2'd0) ? rdata : '0;
  assign m1_readdata = (busy && grant == 2'd1) ? rdata : '0;
  assign m2_readdata = (busy && grant == 2'd2) ? rdata : '0;
  // Grant FSM, round-robin pointer, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 2'd0;
      rr_ptr <= 2'd1;
      cnt <= '0;
      timeout_err <= 1'b0;
      timeout_addr <= '0;
    end else begin
      if (state == IDLE) begin
        if (r0 || r1 || r2) begin
          state <= BUSY;
          grant <= pick;
          cnt <= '0;
        end
      end else if (!active) begin
        state <= IDLE;
      end else if (!s_waitrequest || forced) begin
        state <= IDLE;
        if (grant != 2'd0) rr_ptr <= grant == 2'd1 ? 2'd2 : 2'd1;
      end else if (cnt != TMAX) begin
        cnt <= cnt + 1'b1;
      end
      if (forced && (!timeout_err || err_clr)) begin
        timeout_err <= 1'b1;
        timeout_addr <= g_addr;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end
endmodule
